// File: rtl/reg_file_pkg.sv
// Shared sizing and types for the integer register file.
// Defaults: 32 registers of 32 bits, addressed with 5 bits.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ADDR_W    = $clog2(NREGS_DEF);

  typedef logic [XLEN_DEF-1:0] word_t;
  typedef logic [ADDR_W-1:0]   regAddr_t;

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: address mux with x0 forced to zero.
// Optional same-cycle write forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [ADDR_W-1:0]          addr,
`ifdef REG_FILE_BYPASS_EN
  input  logic                       wrEn,
  input  logic [ADDR_W-1:0]          wrAddr,
  input  logic [XLEN-1:0]            wrData,
`endif
  output logic [XLEN-1:0]            data
);

  always_comb begin
    data = '0;
    if (addr != '0) begin
      data = regs[addr];
`ifdef REG_FILE_BYPASS_EN
      // wrEn already folds in reset and the x0 exclusion
      if (wrEn && (wrAddr == addr)) begin
        data = wrData;
      end
`endif
    end
  end

endmodule

// File: rtl/reg_file.sv
// NREGS x XLEN register file: one write port, two combinational read ports.
// Define REG_FILE_BYPASS_EN to forward the in-flight write to the read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RegWEn,
  input  logic [ADDR_W-1:0] AddrD,
  input  logic [XLEN-1:0]   DataD,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  output logic [XLEN-1:0]   DataA,
  output logic [XLEN-1:0]   DataB
);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic                       wrValid;

  // x0 is never written, so its storage stays at the reset value of zero
  assign wrValid = RST_N && RegWEn && (AddrD != '0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      regs <= '0;
    end else if (wrValid) begin
      regs[AddrD] <= DataD;
    end
  end

  reg_file_rdport #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) uPortA (
    .regs   (regs),
    .addr   (AddrA),
`ifdef REG_FILE_BYPASS_EN
    .wrEn   (wrValid),
    .wrAddr (AddrD),
    .wrData (DataD),
`endif
    .data   (DataA)
  );

  reg_file_rdport #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) uPortB (
    .regs   (regs),
    .addr   (AddrB),
`ifdef REG_FILE_BYPASS_EN
    .wrEn   (wrValid),
    .wrAddr (AddrD),
    .wrData (DataD),
`endif
    .data   (DataB)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file at default sizing.
// Expected values for same-cycle forwarding follow REG_FILE_BYPASS_EN.
module tb_reg_file;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RegWEn;
  logic [4:0]  AddrD;
  logic [31:0] DataD;
  logic [4:0]  AddrA;
  logic [4:0]  AddrB;
  logic [31:0] DataA;
  logic [31:0] DataB;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [32];
  logic [31:0] expColl;

  reg_file dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .RegWEn (RegWEn),
    .AddrD  (AddrD),
    .DataD  (DataD),
    .AddrA  (AddrA),
    .AddrB  (AddrB),
    .DataA  (DataA),
    .DataB  (DataB)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    RegWEn = 1'b1;
    AddrD  = a;
    DataD  = d;
    tick();
    RegWEn = 1'b0;
  endtask

  initial begin
    RST_N  = 1'b0;
    RegWEn = 1'b0;
    AddrD  = '0;
    DataD  = '0;
    AddrA  = 5'd5;
    AddrB  = 5'd31;
    tick();
    tick();
    check("reset_a", DataA, 32'h0);
    check("reset_b", DataB, 32'h0);

    // write then reset with a simultaneous write
    RST_N = 1'b1;
    writeReg(5'd5, 32'h12345678);
    check("pre_reset_x5", DataA, 32'h12345678);
    RST_N  = 1'b0;
    RegWEn = 1'b1;
    AddrD  = 5'd6;
    DataD  = 32'h00000077;
    AddrB  = 5'd6;
    tick();
    tick();
    check("reset_clears_x5", DataA, 32'h0);
    check("reset_beats_write", DataB, 32'h0);

    // first edge after reset release writes
    RST_N = 1'b1;
    writeReg(5'd6, 32'h00000066);
    check("write_after_reset", DataB, 32'h00000066);

    writeReg(5'd3, 32'd22);
    AddrA = 5'd3;
    AddrB = 5'd3;
    #1;
    check("x3_port_a", DataA, 32'd22);
    check("x3_port_b", DataB, 32'd22);

    writeReg(5'd0, 32'hFFFFFFFF);
    AddrA = 5'd0;
    #1;
    check("x0_reads_zero", DataA, 32'h0);

    writeReg(5'd7, 32'hAAAA0000);
    RegWEn = 1'b0;
    AddrD  = 5'd7;
    DataD  = 32'h00005555;
    AddrA  = 5'd7;
    for (int i = 0; i < 10; i++) tick();
    check("x7_write_disabled", DataA, 32'hAAAA0000);

    // same-cycle collision on x9, and bypass never forwards for x0
    writeReg(5'd9, 32'h00000001);
`ifdef REG_FILE_BYPASS_EN
    expColl = 32'hDEADBEEF;
`else
    expColl = 32'h00000001;
`endif
    RegWEn = 1'b1;
    AddrD  = 5'd9;
    DataD  = 32'hDEADBEEF;
    AddrA  = 5'd9;
    AddrB  = 5'd3;
    #1;
    check("collide_before_edge", DataA, expColl);
    check("collide_other_port", DataB, 32'd22);
    tick();
    RegWEn = 1'b0;
    check("collide_after_edge", DataA, 32'hDEADBEEF);
    RegWEn = 1'b1;
    AddrD  = 5'd0;
    DataD  = 32'h13579BDF;
    AddrB  = 5'd0;
    #1;
    check("x0_no_bypass", DataB, 32'h0);
    tick();
    RegWEn = 1'b0;

    // clear, then sweep with enable blocks of 8 cycles
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      AddrD  = 5'(i);
      DataD  = $urandom;
      RegWEn = ((i / 8) % 2) == 0;
      if (RegWEn) model[i] = DataD;
      tick();
    end
    RegWEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      AddrA = 5'(i);
      AddrB = 5'($urandom_range(0, 31));
      #1;
      check($sformatf("sweep_a[%0d]", i), DataA, model[i]);
      check($sformatf("sweep_b[%0d]", AddrB), DataB, model[AddrB]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
